// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multi-cycle RV32I control sequencer (PC, IR, stage enables); optional traps via RV_CTRL_TRAP_EN
module riscv_mc_controller #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 16,
  parameter logic [XLEN-1:0] TRAP_VEC      = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            alu_en,
  output logic            reg_we,
  output logic            retire,
  output logic            fetch_timeout,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_epc
);

`ifdef RV_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [2:0] {
    S_WAIT, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   epc_q;
  logic [CNT_W-1:0]  to_cnt;
  logic              instr_load, pc_load, pc_trap, epc_load;

  logic [6:0]        opcode;
  logic              is_load, is_store, is_branch, is_jal, is_jalr, is_legal, redirect;
  logic [XLEN-1:0]   target_raw, target;
  logic              misaligned;

  assign opcode    = instr_q[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_legal  = is_load || is_store || is_branch || is_jal || is_jalr ||
                     (opcode == OP_OP) || (opcode == OP_OPIMM) ||
                     (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign redirect  = is_jal || is_jalr || (is_branch && branch_taken);

  // Next-PC selection; sums wrap naturally at XLEN bits
  always_comb begin
    target_raw = pc_q + XLEN'(4);
    if (is_jal || (is_branch && branch_taken)) target_raw = pc_q + imm;
    else if (is_jalr)                          target_raw = {alu_result[XLEN-1:1], 1'b0};
  end

  // Without traps a misaligned target is silently aligned down to a word
  assign misaligned = (target_raw[1:0] != 2'b00);
  assign target     = TRAP_EN ? target_raw : {target_raw[XLEN-1:2], 2'b00};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  // Next-state and per-stage strobes; strobes decode from the registered state
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    retire     = 1'b0;
    instr_load = 1'b0;
    pc_load    = 1'b0;
    pc_trap    = 1'b0;
    epc_load   = 1'b0;
    case (state_q)
      S_WAIT: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_load = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (TRAP_EN && !is_legal) begin
          epc_load = 1'b1;
          state_d  = S_TRAP;
        end else begin
          state_d  = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (TRAP_EN && redirect && misaligned) begin
          epc_load = 1'b1;
          state_d  = S_TRAP;
        end else if (is_load || is_store) begin
          state_d = S_MEMORY;
        end else if (is_branch || !is_legal) begin
          pc_load = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        reg_we  = 1'b1;
        pc_load = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        pc_trap = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // PC, instruction register, trap EPC and fetch-timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0013;
      epc_q         <= '0;
      to_cnt        <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      fetch_timeout <= 1'b0;
      if (instr_load) instr_q <= imem_rdata;
      if (pc_trap)      pc_q <= TRAP_VEC;
      else if (pc_load) pc_q <= target;
      if (epc_load) epc_q <= pc_q;
      // An ack in the limit cycle clears the count without pulsing
      if (state_q == S_FETCH && !imem_ack) begin
        if (to_cnt == CNT_W'(FETCH_TIMEOUT - 1)) begin
          to_cnt        <= '0;
          fetch_timeout <= 1'b1;
        end else begin
          to_cnt <= to_cnt + CNT_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign trap_valid = TRAP_EN && (state_q == S_TRAP);
  assign trap_epc   = TRAP_EN ? epc_q : '0;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb/tb_riscv_mc_controller.sv - directed scoreboard bench for riscv_mc_controller
module tb_riscv_mc_controller;
  localparam int          XLEN = 32;
  localparam int          FT   = 16;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] imem_addr, imm, alu_result, pc, trap_epc;
  logic [31:0]     imem_rdata, instr;
  logic            branch_taken, alu_en, reg_we, retire, fetch_timeout, trap_valid;

  always #5 clk = ~clk;

  riscv_mc_controller #(
    .XLEN(XLEN), .RESET_PC(32'h0), .FETCH_TIMEOUT(FT), .TRAP_VEC(TVEC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .imm(imm), .alu_result(alu_result), .branch_taken(branch_taken),
    .instr(instr), .pc(pc), .alu_en(alu_en), .reg_we(reg_we), .retire(retire),
    .fetch_timeout(fetch_timeout), .trap_valid(trap_valid), .trap_epc(trap_epc)
  );

  typedef struct {
    logic [31:0] pc;
    int          we;
    int          alu;
    int          mem;
    logic        memwe;
    logic        trap;
    logic [31:0] epc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;

`ifdef RV_CTRL_TRAP_EN
  localparam bit TB_TRAP = 1'b1;
`else
  localparam bit TB_TRAP = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] iw, input int fwait,
                           input logic [31:0] imm_v, input logic [31:0] alu_v, input logic taken,
                           input int mcyc, input logic [31:0] exp_pc, input int exp_we,
                           input logic exp_trap);
    exp_t        e, g;
    int          n, to_bad, alu_cnt, we_cnt, mem_cnt, memwe_bad;
    logic [31:0] addr0;
    logic        addr_bad, done, ret_seen;
    e.pc    = exp_pc;
    e.we    = exp_we;
    e.alu   = (exp_trap && iw[6:0] == 7'h7F) ? 0 : 1;
    e.mem   = mcyc;
    e.memwe = (iw[6:0] == 7'h23);
    e.trap  = exp_trap;
    e.epc   = model_pc;
    sb.push_back(e);
    imm = imm_v; alu_result = alu_v; branch_taken = taken; imem_ack = 1'b0; dmem_ack = 1'b0;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, ":fetch_req"}, imem_req, 1);
    check({tag, ":fetch_addr"}, imem_addr, model_pc);
    addr0 = imem_addr; addr_bad = 1'b0; to_bad = 0;
    for (int k = 1; k < fwait; k++) begin
      @(negedge clk); #1;
      if (imem_addr !== addr0 || imem_req !== 1'b1) addr_bad = 1'b1;
      if (fetch_timeout !== ((k % FT) == 0)) to_bad++;
    end
    @(negedge clk); imem_ack = 1'b1; imem_rdata = iw; #1;
    if (imem_addr !== addr0 || imem_req !== 1'b1) addr_bad = 1'b1;
    if (fetch_timeout !== ((fwait % FT) == 0)) to_bad++;
    check({tag, ":addr_stable"}, addr_bad, 0);
    @(negedge clk); imem_ack = 1'b0;
    alu_cnt = 0; we_cnt = 0; mem_cnt = 0; memwe_bad = 0; done = 1'b0; ret_seen = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      dmem_ack = (dmem_req === 1'b1) && (mem_cnt == mcyc - 1);
      #1;
      if (c == 0 && fetch_timeout !== 1'b0) to_bad++;
      if (alu_en === 1'b1) alu_cnt++;
      if (reg_we === 1'b1) we_cnt++;
      if (dmem_req === 1'b1) begin
        mem_cnt++;
        if (dmem_we !== e.memwe) memwe_bad++;
      end
      if (retire === 1'b1 || trap_valid === 1'b1) begin
        done = 1'b1;
        ret_seen = retire;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, ":completed"}, done, 1);
    g = sb.pop_front();
    check({tag, ":retire_vs_trap"}, ret_seen, !g.trap);
    @(negedge clk); dmem_ack = 1'b0; #1;
    check({tag, ":pc"}, pc, g.pc);
    check({tag, ":instr"}, instr, iw);
    check({tag, ":reg_we_cycles"}, we_cnt, g.we);
    check({tag, ":alu_en_cycles"}, alu_cnt, g.alu);
    check({tag, ":dmem_req_cycles"}, mem_cnt, g.mem);
    check({tag, ":dmem_we"}, memwe_bad, 0);
    check({tag, ":fetch_timeout"}, to_bad, 0);
    if (g.trap) check({tag, ":trap_epc"}, trap_epc, g.epc);
    model_pc = g.pc;
  endtask

  initial begin
    int n;
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
    imm = '0; alu_result = '0; branch_taken = 1'b0; model_pc = 32'h0;
    repeat (2) @(negedge clk); #1;
    check("rst:pc", pc, 32'h0);
    check("rst:instr", instr, 32'h0000_0013);
    check("rst:imem_req", imem_req, 0);
    check("rst:dmem_req", dmem_req, 0);
    check("rst:strobes", {alu_en, reg_we, retire, fetch_timeout, trap_valid}, 0);
    check("rst:trap_epc", trap_epc, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("wait:imem_req", imem_req, 0);
    @(negedge clk); #1;

    run_instr("addi",     32'h0050_0093, 3,  32'h0,        32'h0,        1'b0, 0, 32'h0000_0004, 1, 1'b0);
    run_instr("jal_20",   32'h01C0_006F, 1,  32'h1C,       32'h0,        1'b0, 0, 32'h0000_0020, 1, 1'b0);
    run_instr("beq_tk",   32'hFE00_0CE3, 1,  32'hFFFF_FFF8, 32'h0,       1'b1, 0, 32'h0000_0018, 0, 1'b0);
    run_instr("jal_back", 32'h0080_006F, 2,  32'h8,        32'h0,        1'b0, 0, 32'h0000_0020, 1, 1'b0);
    run_instr("beq_nt",   32'hFE00_0CE3, 1,  32'hFFFF_FFF8, 32'h0,       1'b0, 0, 32'h0000_0024, 0, 1'b0);
    run_instr("sw",       32'h0011_2023, 1,  32'h0,        32'h0,        1'b0, 5, 32'h0000_0028, 0, 1'b0);
    run_instr("lw",       32'h0001_2083, 2,  32'h0,        32'h0,        1'b0, 2, 32'h0000_002C, 1, 1'b0);
    run_instr("timeout",  32'h0050_0093, 40, 32'h0,        32'h0,        1'b0, 0, 32'h0000_0030, 1, 1'b0);
    run_instr("ack_wins", 32'h0050_0093, 15, 32'h0,        32'h0,        1'b0, 0, 32'h0000_0034, 1, 1'b0);
    run_instr("jalr_top", 32'h0000_8067, 1,  32'h0,        32'hFFFF_FFFC, 1'b0, 0, 32'hFFFF_FFFC, 1, 1'b0);
    run_instr("wrap",     32'h0050_0093, 1,  32'h0,        32'h0,        1'b0, 0, 32'h0000_0000, 1, 1'b0);
    run_instr("addi_4",   32'h0050_0093, 1,  32'h0,        32'h0,        1'b0, 0, 32'h0000_0004, 1, 1'b0);
    run_instr("jalr_mis", 32'h0000_8067, 1,  32'h0,        32'h0000_0103, 1'b0, 0, 32'h0000_0100,
              TB_TRAP ? 0 : 1, TB_TRAP);
    run_instr("illegal",  32'h0000_007F, 1,  32'h0,        32'h0,        1'b0, 0,
              TB_TRAP ? TVEC : 32'h0000_0104, 0, TB_TRAP);

    imm = '0; imem_ack = 1'b0;
    check("rstmem:fetch_req", imem_req, 1);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h0011_2023;
    @(negedge clk); imem_ack = 1'b0; #1;
    n = 0;
    while (dmem_req !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    check("rstmem:dmem_req", dmem_req, 1);
    #2 reset = 1'b1; #1;
    check("rstmem:req_drop", {dmem_req, imem_req}, 0);
    check("rstmem:pc", pc, 32'h0);
    dmem_ack = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    check("rstmem:wait_idle", {imem_req, dmem_req, retire}, 0);
    @(negedge clk); #1;
    check("rstmem:ack_ignored", {imem_req, dmem_req, retire}, 3'b100);
    dmem_ack = 1'b0;
    model_pc = 32'h0;
    run_instr("post_rst", 32'h0050_0093, 2, 32'h0, 32'h0, 1'b0, 0, 32'h0000_0004, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
